// File: rtl/reg_bus_endpoint_if.sv
// Per-component register bus: single-cycle write/read strobes from the host
// bridge and the registered one-cycle read response.
interface reg_bus_endpoint_if;
  logic        wvalid;
  logic [15:0] waddr;
  logic [31:0] wdata;
  logic        arvalid;
  logic [15:0] araddr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output wvalid, waddr, wdata, arvalid, araddr,
                  input  rvalid, rdata);
  modport slave  (input  wvalid, waddr, wdata, arvalid, araddr,
                  output rvalid, rdata);
endinterface

// File: rtl/reg_bus_endpoint.sv
// Register bus responder: config registers, 64-bit event counter with MSB
// snapshot, and a host-drained log FIFO with drop counting.
module reg_bus_endpoint #(
  parameter int unsigned ID             = 1,
  parameter int unsigned N_CFG          = 4,
  parameter int unsigned LOG_FIFO_DEPTH = 4,
  parameter logic [31:0] CFG_RESET      = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_bus_endpoint_if.slave     reg_bus,
  output logic [32*N_CFG-1:0]   cfg_out,
  input  logic                  event_inc,
  input  logic                  log_wvalid,
  input  logic [31:0]           log_wdata,
  output logic                  log_wready
);

  localparam int unsigned DEPTH = 1 << LOG_FIFO_DEPTH;

  typedef logic [LOG_FIFO_DEPTH-1:0] ptr_t;
  typedef logic [LOG_FIFO_DEPTH:0]   occ_t;

  localparam occ_t FULL_OCC = occ_t'(DEPTH);

  typedef enum logic [5:0] {
    W_EVT_LSB  = 6'h10,
    W_EVT_MSB  = 6'h11,
    W_LOG_POP  = 6'h14,
    W_LOG_OCC  = 6'h15,
    W_LOG_DROP = 6'h16,
    W_ID       = 6'h17
  } reg_word_e;

  logic [5:0]  wa, ra;
  logic [31:0] cfg_q [N_CFG];
  logic [63:0] evt_cnt;
  logic [31:0] evt_snap;
  logic [31:0] fifo_mem [DEPTH];
  ptr_t        wr_ptr, rd_ptr;
  occ_t        occ, occ_next;
  logic [31:0] dropped;
  logic        fifo_full, fifo_empty, do_pop, do_push, do_drop;
  logic [31:0] rd_mux;
  logic        unused_addr_bits;

  assign wa = reg_bus.waddr[7:2];
  assign ra = reg_bus.araddr[7:2];
  assign unused_addr_bits = ^{reg_bus.waddr[15:8], reg_bus.waddr[1:0],
                              reg_bus.araddr[15:8], reg_bus.araddr[1:0]};

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  always_comb begin
    fifo_full  = (occ == FULL_OCC);
    fifo_empty = (occ == '0);
    do_pop     = reg_bus.arvalid && (ra == W_LOG_POP) && !fifo_empty;
    do_push    = log_wvalid && (!fifo_full || do_pop);
    do_drop    = log_wvalid && !do_push;
    occ_next   = occ;
    if (do_push && !do_pop)      occ_next = occ + occ_t'(1);
    else if (do_pop && !do_push) occ_next = occ - occ_t'(1);
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned k = 0; k < N_CFG; k++) begin
      if (ra == 6'(k)) rd_mux = cfg_q[k];
    end
    case (ra)
      W_EVT_LSB:  rd_mux = evt_cnt[31:0];
      W_EVT_MSB:  rd_mux = evt_snap;
      W_LOG_POP:  rd_mux = fifo_empty ? '0 : fifo_mem[rd_ptr];
      W_LOG_OCC:  rd_mux = 32'(occ);
      W_LOG_DROP: rd_mux = dropped;
      W_ID:       rd_mux = 32'(ID);
      default:    ;
    endcase
  end

  always_comb begin
    cfg_out = '0;
    for (int unsigned k = 0; k < N_CFG; k++) cfg_out[32*k +: 32] = cfg_q[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_bus.rvalid <= 1'b0;
      reg_bus.rdata  <= '0;
    end else begin
      reg_bus.rvalid <= reg_bus.arvalid;
      if (reg_bus.arvalid) reg_bus.rdata <= rd_mux;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_CFG; k++) cfg_q[k] <= CFG_RESET;
    end else if (reg_bus.wvalid) begin
      for (int unsigned k = 0; k < N_CFG; k++) begin
        if (wa == 6'(k)) cfg_q[k] <= reg_bus.wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_cnt  <= '0;
      evt_snap <= '0;
    end else begin
      if (reg_bus.wvalid && wa == W_EVT_LSB) evt_cnt <= '0;
      else if (event_inc)                    evt_cnt <= evt_cnt + 64'd1;
      if (reg_bus.arvalid && ra == W_EVT_LSB) evt_snap <= evt_cnt[63:32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      dropped    <= '0;
      log_wready <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      occ        <= occ_next;
      log_wready <= (occ_next != FULL_OCC);
      if (reg_bus.wvalid && wa == W_LOG_DROP) dropped <= '0;
      else if (do_drop && dropped != '1)      dropped <= dropped + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= log_wdata;
  end

endmodule
